// File: rtl/cga_scanout.sv
// Read-side scan-out for the scan converter: 15 kHz monitor timing, frame-buffer
// read addressing and RGB 3-3-2 pixel capture, all advancing on the arbiter tick t3.
module cga_scanout #(
  parameter int unsigned H_ACTIVE    = 256,
  parameter int unsigned H_FP        = 24,
  parameter int unsigned H_SYNC      = 32,
  parameter int unsigned H_BP        = 72,
  parameter int unsigned V_ACTIVE    = 224,
  parameter int unsigned V_FP        = 16,
  parameter int unsigned V_SYNC      = 3,
  parameter int unsigned V_BP        = 19,
  parameter int unsigned LINE_STRIDE = 256,
  parameter int          ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              t3,
  output logic [ADDR_W-1:0] aCga,
  input  logic [7:0]        dCga,
  output logic [2:0]        red,
  output logic [2:0]        green,
  output logic [1:0]        blue,
  output logic              hsync_n,
  output logic              vsync_n,
  output logic              csync_n,
  output logic              blank,
  output logic              frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int          HCNT_W  = $clog2(H_TOTAL);
  localparam int          VCNT_W  = $clog2(V_TOTAL);

  // Linear frame-buffer address; the product is formed wide and truncated on purpose.
  function automatic logic [ADDR_W-1:0] pixAddr(input logic [VCNT_W-1:0] v,
                                                input logic [HCNT_W-1:0] h);
    logic [63:0] full;
    full = 64'(v) * 64'(LINE_STRIDE) + 64'(h);
    return full[ADDR_W-1:0];
  endfunction

  logic [HCNT_W-1:0] hCnt;
  logic [VCNT_W-1:0] vCnt;
  logic              active_p0, hs_p0, vs_p0, hLast, vLast;
  logic              hs_p1, vs_p1, bl_p1;
  logic [7:0]        pix_p2;

  always_comb begin
    active_p0 = (32'(hCnt) < H_ACTIVE) && (32'(vCnt) < V_ACTIVE);
    hs_p0     = (32'(hCnt) >= H_ACTIVE + H_FP) && (32'(hCnt) < H_ACTIVE + H_FP + H_SYNC);
    vs_p0     = (32'(vCnt) >= V_ACTIVE + V_FP) && (32'(vCnt) < V_ACTIVE + V_FP + V_SYNC);
    hLast     = (32'(hCnt) == H_TOTAL - 1);
    vLast     = (32'(vCnt) == V_TOTAL - 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hCnt        <= '0;
      vCnt        <= '0;
      aCga        <= '0;
      hs_p1       <= 1'b0;
      vs_p1       <= 1'b0;
      bl_p1       <= 1'b1;
      pix_p2      <= '0;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      csync_n     <= 1'b1;
      blank       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (t3) begin
        hCnt <= hLast ? '0 : hCnt + 1'b1;
        if (hLast) vCnt <= vLast ? '0 : vCnt + 1'b1;
        frame_start <= (hCnt == '0) && (vCnt == '0);

        // Stage 1: address issue and raw timing, one tick ahead of the returned byte
        if (active_p0) aCga <= pixAddr(vCnt, hCnt);
        hs_p1 <= hs_p0;
        vs_p1 <= vs_p0;
        bl_p1 <= ~active_p0;

        // Stage 2: byte for the previous address arrives now, aligned with its timing
        pix_p2  <= bl_p1 ? 8'h00 : dCga;
        hsync_n <= ~hs_p1;
        vsync_n <= ~vs_p1;
        csync_n <= ~(hs_p1 | vs_p1);
        blank   <= bl_p1;
      end
    end
  end

  assign red   = pix_p2[7:5];
  assign green = pix_p2[4:2];
  assign blue  = pix_p2[1:0];

endmodule

// File: tb/tb_cga_scanout.sv
// Scoreboard bench for cga_scanout with a reduced raster so full frames fit a short run;
// expected values are derived from the tick index since the last reset.
module tb_cga_scanout;

  localparam int HA = 16, HF = 4, HS = 4, HB = 8;
  localparam int VA = 12, VF = 2, VS = 3, VB = 3;
  localparam int LS = 20, AW = 16;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic          clk = 1'b0;
  logic          reset, t3;
  logic [7:0]    dCga;
  logic [AW-1:0] aCga;
  logic [2:0]    red, green;
  logic [1:0]    blue;
  logic          hsync_n, vsync_n, csync_n, blank, frame_start;

  cga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .LINE_STRIDE(LS), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .t3(t3), .aCga(aCga), .dCga(dCga),
    .red(red), .green(green), .blue(blue),
    .hsync_n(hsync_n), .vsync_n(vsync_n), .csync_n(csync_n),
    .blank(blank), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    pix;
    logic          hs_n, vs_n, cs_n, bl, fs;
  } exp_t;

  exp_t    sbQ[$];
  exp_t    lastExp;
  int      nChecks = 0;
  int      nPass = 0;
  int      tickIdx = 0;
  int      maxSeen = 0;
  logic [AW-1:0] lastAddr = '0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int hOf(input int k); return k % HT; endfunction
  function automatic int vOf(input int k); return (k / HT) % VT; endfunction
  function automatic bit isActive(input int k); return hOf(k) < HA && vOf(k) < VA; endfunction
  function automatic bit isHs(input int k); return hOf(k) >= HA + HF && hOf(k) < HA + HF + HS; endfunction
  function automatic bit isVs(input int k); return vOf(k) >= VA + VF && vOf(k) < VA + VF + VS; endfunction

  function automatic exp_t resetExp();
    exp_t e;
    e.addr = '0; e.pix = 8'h00;
    e.hs_n = 1'b1; e.vs_n = 1'b1; e.cs_n = 1'b1; e.bl = 1'b1; e.fs = 1'b0;
    return e;
  endfunction

  task automatic compareOut(input exp_t e, input string sfx);
    checkVal({"aCga", sfx}, 32'(aCga), 32'(e.addr));
    checkVal({"red", sfx}, 32'(red), 32'(e.pix[7:5]));
    checkVal({"green", sfx}, 32'(green), 32'(e.pix[4:2]));
    checkVal({"blue", sfx}, 32'(blue), 32'(e.pix[1:0]));
    checkVal({"hsync_n", sfx}, 32'(hsync_n), 32'(e.hs_n));
    checkVal({"vsync_n", sfx}, 32'(vsync_n), 32'(e.vs_n));
    checkVal({"csync_n", sfx}, 32'(csync_n), 32'(e.cs_n));
    checkVal({"blank", sfx}, 32'(blank), 32'(e.bl));
    checkVal({"frame_start", sfx}, 32'(frame_start), 32'(e.fs));
  endtask

  task automatic tick(input logic [7:0] d);
    exp_t e;
    int   k;
    string sfx;
    k = tickIdx;
    sfx = $sformatf("@t%0d", k);
    @(negedge clk);
    t3 = 1'b1;
    dCga = d;
    if (isActive(k)) lastAddr = AW'((vOf(k) * LS + hOf(k)) & 32'h0000_FFFF);
    e.addr = lastAddr;
    e.fs = (hOf(k) == 0) && (vOf(k) == 0);
    if (k == 0) begin
      e.pix = 8'h00; e.hs_n = 1'b1; e.vs_n = 1'b1; e.cs_n = 1'b1; e.bl = 1'b1;
    end else begin
      e.bl   = !isActive(k - 1);
      e.pix  = isActive(k - 1) ? d : 8'h00;
      e.hs_n = !isHs(k - 1);
      e.vs_n = !isVs(k - 1);
      e.cs_n = !(isHs(k - 1) || isVs(k - 1));
    end
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    lastExp = sbQ.pop_front();
    compareOut(lastExp, sfx);
    if (int'(aCga) > maxSeen) maxSeen = int'(aCga);
    @(negedge clk);
    t3 = 1'b0;
    @(posedge clk);
    #1 checkVal({"fsPulse", sfx}, 32'(frame_start), 32'(0));
    lastExp.fs = 1'b0;
    repeat (2) @(posedge clk);
    tickIdx++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 compareOut(lastExp, $sformatf("@hold%0d", i));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    t3 = 1'b0;
    dCga = 8'h00;
    repeat (3) @(posedge clk);
    #1 compareOut(resetExp(), "@rst0");
    @(negedge clk);
    reset = 1'b0;
    tickIdx = 0;
    lastAddr = '0;

    for (int i = 0; i < FRAME + 40; i++)
      tick((i < FRAME) ? 8'hE5 : 8'($urandom_range(0, 255)));

    idle(100);
    for (int i = 0; i < 30; i++) tick(8'($urandom_range(0, 255)));

    while ((tickIdx % FRAME) != 5 * HT + 10) tick(8'($urandom_range(0, 255)));
    @(negedge clk);
    reset = 1'b1;
    t3 = 1'b1;
    dCga = 8'h5A;
    @(posedge clk);
    #1 compareOut(resetExp(), "@rstMid");
    @(negedge clk);
    reset = 1'b0;
    t3 = 1'b0;
    tickIdx = 0;
    lastAddr = '0;
    for (int i = 0; i < 100; i++) tick(8'($urandom_range(0, 255)));

    checkVal("addrMax", 32'(maxSeen), 32'((VA - 1) * LS + HA - 1));
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
